muldiv_unit: RTL and testbench
==============================

// Module: muldiv_unit
// PURPOSE
//   Iterative multiply/divide unit with HI/LO registers for the MIPS core.
//   Sits beside the combinational alu in EX. Executes MULT/MULTU/DIV/DIVU over several cycles.
//   Provides MTHI/MTLO writes. HI/LO are always readable for MFHI/MFLO.
//   Radix-2 shift-add / restoring-divide datapath, generalised to DATA_WIDTH.
// PARAMETERS
//   DATA_WIDTH  32  operand/HI/LO width (W); even, >= 4
// PORTS
//   clk       in   1    clock, all state updates on rising edge
//   rst       in   1    synchronous, active-high reset
//   start     in   1    request; sampled only when busy=0
//   op        in   3    0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6-7 reserved
//   rega      in   W    multiplicand / dividend / MTHI-MTLO data
//   regb      in   W    multiplier / divisor
//   busy      out  1    operation in progress; new start ignored
//   done      out  1    one-cycle pulse: hi/lo hold the new result
//   hi        out  W    HI register (product upper half / remainder)
//   lo        out  W    LO register (product lower half / quotient)
//   div_zero  out  1    latched: last DIV/DIVU had regb=0; cleared by next accepted op
// BEHAVIOUR
//   Reset: state=IDLE, busy=0, done=0, hi=0, lo=0, div_zero=0.
//   Reset mid-operation aborts it. No done is produced and hi/lo are cleared.
//   FSM: IDLE -> CALC (W cycles, 1 bit/cycle, internal counter W-1..0) -> FINISH (1 cycle) -> IDLE.
//   Accept: start=1 and busy=0 in cycle N. Operands are latched at that edge.
//   Operands are converted to magnitudes; the result sign is recorded.
//   busy=1 in cycles N+1 .. N+W+1. FINISH applies sign correction and writes hi/lo.
//   In cycle N+W+2: done=1, busy=0, new hi/lo visible. A new start is accepted in that same cycle.
//   Latency: W+2 cycles start->done (34 for W=32).
//   start while busy=1 is ignored. There is no queueing and operands are not re-sampled.
//   MTHI/MTLO (idle only) write rega to hi/lo at the accepting edge; the other register is unchanged.
//   For MTHI/MTLO, busy stays 0 and done=1 in cycle N+1.
//   Reserved op: no state change, no busy, no done.
//   MULT/MULTU: {hi,lo} = full 2W-bit product, signed or unsigned respectively.
//   DIV/DIVU: lo = quotient truncated toward zero; hi = remainder, sign of dividend.
//   Divide by zero (regb=0): lo = all ones, hi = rega unchanged, div_zero=1.
//   This case takes the normal W+2 latency.
//   DIV overflow (rega = 1<<(W-1), regb = all ones): lo = 1<<(W-1), hi = 0. No flag.
//   hi/lo never change except at FINISH, MTHI/MTLO, or reset.
//   During busy, hi/lo hold their previous values.
// TESTING  (W=32)
//   MULTU FFFFFFFF*FFFFFFFF -> hi=FFFFFFFE lo=00000001; done exactly 34 cycles after start.
//   MULT FFFFFFFE*00000003 -> hi=FFFFFFFF lo=FFFFFFFA; busy high 33 cycles.
//   DIV FFFFFFF9/00000002 -> lo=FFFFFFFD hi=FFFFFFFF.
//   DIVU 7/2 -> lo=3 hi=1.
//   DIV 80000000/FFFFFFFF -> lo=80000000 hi=0.
//   DIVU 5/0 -> lo=FFFFFFFF hi=5 div_zero=1. Next MULTU clears div_zero.
//   MTHI 12345678 then MTLO 9ABCDEF0 -> hi=12345678 lo=9ABCDEF0; each gives done next cycle.
//   start during busy changes nothing.
//   rst at CALC cycle 10 -> busy=0 hi=lo=0, no done pulse.

Source files
------------

// File: rtl/muldiv_unit.sv
// Iterative radix-2 multiply / restoring-divide unit with HI/LO registers.
// Operands are reduced to magnitudes on accept; sign is restored in FINISH.
module muldiv_unit #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [2:0]            op,
  input  logic [DATA_WIDTH-1:0] rega,
  input  logic [DATA_WIDTH-1:0] regb,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] hi,
  output logic [DATA_WIDTH-1:0] lo,
  output logic                  div_zero
);

  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(W);

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  typedef enum logic [1:0] {IDLE, CALC, FINISH} state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [W-1:0]    acc;
  logic [W-1:0]    q;
  logic [W-1:0]    m;
  logic            is_div;
  logic            neg_q;
  logic            neg_r;
  logic            dz;

  logic            signed_op;
  logic            a_neg;
  logic            b_neg;
  logic            accept_arith;
  logic [W:0]      mul_sum;
  logic [W:0]      div_shift;
  logic            div_ge;
  logic [W-1:0]    div_diff;

  function automatic logic [W-1:0] mag(input logic [W-1:0] v, input logic sgn);
    return (sgn && v[W-1]) ? -v : v;
  endfunction

  function automatic logic [W-1:0] cond_neg(input logic [W-1:0] v, input logic n);
    return n ? -v : v;
  endfunction

  function automatic logic [2*W-1:0] cond_neg2(input logic [2*W-1:0] v, input logic n);
    return n ? -v : v;
  endfunction

  always_comb begin
    signed_op    = ~op[0];
    a_neg        = signed_op & rega[W-1];
    b_neg        = signed_op & regb[W-1];
    accept_arith = (state == IDLE) && start && !op[2];
    mul_sum      = {1'b0, acc} + (q[0] ? {1'b0, m} : {(W+1){1'b0}});
    div_shift    = {acc, q[W-1]};
    div_ge       = div_shift >= {1'b0, m};
    // when div_ge holds the true difference is below m, so W bits suffice
    div_diff     = div_shift[W-1:0] - m;
  end

  // Datapath: operand load on accept, one bit per CALC cycle; no reset needed
  always_ff @(posedge clk) begin
    if (accept_arith) begin
      acc    <= '0;
      is_div <= op[1];
      neg_q  <= a_neg ^ b_neg;
      neg_r  <= a_neg;
      if (op[1]) begin
        m  <= mag(regb, signed_op);
        q  <= mag(rega, signed_op);
        dz <= (regb == '0);
      end else begin
        m  <= mag(rega, signed_op);
        q  <= mag(regb, signed_op);
        dz <= 1'b0;
      end
    end else if (state == CALC) begin
      if (is_div) begin
        acc <= div_ge ? div_diff : div_shift[W-1:0];
        q   <= {q[W-2:0], div_ge};
      end else begin
        acc <= mul_sum[W:1];
        q   <= {mul_sum[0], q[W-1:1]};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      hi       <= '0;
      lo       <= '0;
      div_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            case (op)
              OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                state    <= CALC;
                cnt      <= CW'(W - 1);
                busy     <= 1'b1;
                div_zero <= 1'b0;
              end
              OP_MTHI: begin
                hi       <= rega;
                done     <= 1'b1;
                div_zero <= 1'b0;
              end
              OP_MTLO: begin
                lo       <= rega;
                done     <= 1'b1;
                div_zero <= 1'b0;
              end
              default: ;
            endcase
          end
        end
        CALC: begin
          if (cnt == '0) state <= FINISH;
          else           cnt   <= cnt - CW'(1);
        end
        FINISH: begin
          if (is_div) begin
            lo <= dz ? '1 : cond_neg(q, neg_q);
            hi <= cond_neg(acc, neg_r);
          end else begin
            {hi, lo} <= cond_neg2({acc, q}, neg_q);
          end
          div_zero <= dz;
          done     <= 1'b1;
          busy     <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Randomized and directed bench for muldiv_unit against an arithmetic HI/LO model.
module tb_muldiv_unit;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [2:0]   op;
  logic [W-1:0] rega;
  logic [W-1:0] regb;
  logic         busy;
  logic         done;
  logic [W-1:0] hi;
  logic [W-1:0] lo;
  logic         div_zero;

  int checks   = 0;
  int failures = 0;

  logic [W-1:0] m_hi = '0;
  logic [W-1:0] m_lo = '0;
  logic         m_dz = 1'b0;

  muldiv_unit #(.DATA_WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .rega(rega), .regb(regb),
    .busy(busy), .done(done), .hi(hi), .lo(lo), .div_zero(div_zero)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference: MIPS HI/LO semantics expressed with 64-bit integer arithmetic
  task automatic model(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    longint      sa, sb, sq, sr;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (o)
      3'd0: begin p = sa * sb; {m_hi, m_lo} = p; m_dz = 1'b0; end
      3'd1: begin p = {32'b0, a} * {32'b0, b}; {m_hi, m_lo} = p; m_dz = 1'b0; end
      3'd2: begin
        if (b == '0) begin m_lo = '1; m_hi = a; m_dz = 1'b1; end
        else begin
          sq = sa / sb;
          sr = sa % sb;
          m_lo = sq[W-1:0];
          m_hi = sr[W-1:0];
          m_dz = 1'b0;
        end
      end
      3'd3: begin
        if (b == '0) begin m_lo = '1; m_hi = a; m_dz = 1'b1; end
        else begin m_lo = a / b; m_hi = a % b; m_dz = 1'b0; end
      end
      3'd4: begin m_hi = a; m_dz = 1'b0; end
      3'd5: begin m_lo = a; m_dz = 1'b0; end
      default: ;
    endcase
  endtask

  task automatic run_op(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                        input bit poke);
    logic [W-1:0] old_hi, old_lo;
    int cyc, bcyc, held_bad;
    old_hi = m_hi;
    old_lo = m_lo;
    @(negedge clk);
    start = 1'b1; op = o; rega = a; regb = b;
    @(posedge clk); #1;
    start = 1'b0; rega = $urandom; regb = $urandom;
    model(o, a, b);
    if (o < 3'd4) begin
      cyc = 0; bcyc = 0; held_bad = 0;
      while (!done && cyc < 100) begin
        if (busy) bcyc++;
        if (hi !== old_hi || lo !== old_lo) held_bad++;
        if (poke && cyc == 5) begin start = 1'b1; op = 3'd4; rega = $urandom; end
        if (poke && cyc == 6) start = 1'b0;
        @(posedge clk); #1;
        cyc++;
      end
      start = 1'b0;
      chk("latency", cyc, W + 1);
      chk("busy_cycles", bcyc, W + 1);
      chk("hold_during_busy", held_bad, 0);
      chk("busy_at_done", busy, 1'b0);
    end else if (o < 3'd6) begin
      chk("mt_done", done, 1'b1);
      chk("mt_busy", busy, 1'b0);
    end else begin
      chk("rsv_done", done, 1'b0);
      chk("rsv_busy", busy, 1'b0);
    end
    chk("hi", hi, m_hi);
    chk("lo", lo, m_lo);
    chk("div_zero", div_zero, m_dz);
  endtask

  function automatic logic [W-1:0] rnd_val();
    case ($urandom_range(0, 7))
      0: return '0;
      1: return 32'd1;
      2: return '1;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      5: return W'($urandom_range(0, 15));
      default: return W'($urandom);
    endcase
  endfunction

  initial begin
    int ndone;
    rst = 1'b1; start = 1'b0; op = '0; rega = '0; regb = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_hi", hi, '0);
    chk("rst_lo", lo, '0);
    chk("rst_dz", div_zero, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    run_op(3'd0, 32'hFFFF_FFFE, 32'h0000_0003, 1'b1);
    run_op(3'd2, 32'hFFFF_FFF9, 32'h0000_0002, 1'b0);
    run_op(3'd3, 32'd7, 32'd2, 1'b0);
    run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    run_op(3'd3, 32'd5, 32'd0, 1'b0);
    run_op(3'd1, 32'd9, 32'd11, 1'b0);
    run_op(3'd2, 32'h8000_0000, 32'd0, 1'b0);
    run_op(3'd4, 32'h1234_5678, 32'd0, 1'b0);
    run_op(3'd5, 32'h9ABC_DEF0, 32'd0, 1'b0);
    run_op(3'd6, 32'hDEAD_BEEF, 32'd1, 1'b0);
    run_op(3'd7, 32'hCAFE_F00D, 32'd1, 1'b0);

    for (int i = 0; i < 40; i++) begin
      logic [2:0]   o;
      logic [W-1:0] a, b;
      o = 3'($urandom_range(0, 7));
      a = rnd_val();
      b = rnd_val();
      run_op(o, a, b, (i % 7) == 3);
    end

    run_op(3'd4, 32'hA5A5_0001, 32'd0, 1'b0);
    run_op(3'd5, 32'h5A5A_0002, 32'd0, 1'b0);
    @(negedge clk);
    start = 1'b1; op = 3'd1; rega = 32'hFFFF_0000; regb = 32'h0001_FFFF;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    m_hi = '0; m_lo = '0; m_dz = 1'b0;
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_done", done, 1'b0);
    chk("midrst_hi", hi, m_hi);
    chk("midrst_lo", lo, m_lo);
    ndone = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done) ndone++;
    end
    chk("midrst_no_done", ndone, 0);
    chk("midrst_hi_after", hi, m_hi);

    run_op(3'd0, 32'h8000_0000, 32'h8000_0000, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
